// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one 64-bit two-operand float unit among
// four requesters, with a watchdog that aborts transactions the unit never completes.
module fpu_share_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clock_50M,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [255:0] req_f1,
  input  logic [255:0] req_f2,
  input  logic [3:0]   req_sel,
  output logic [3:0]   ack,
  output logic [127:0] result,
  output logic         err,
  output logic         busy,
  output logic [1:0]   grant_id,
  output logic         fault,
  output logic [63:0]  unit_f1,
  output logic [63:0]  unit_f2,
  output logic         unit_sel,
  output logic         unit_start,
  input  logic         unit_done,
  input  logic [127:0] unit_out
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned OPW  = 64;
  localparam int unsigned WDW  = 16;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         state, state_d;
  logic [1:0]     ptr, ptr_d;
  logic [WDW-1:0] wdog, wdog_d;
  logic [3:0]     ack_d;
  logic [127:0]   result_d;
  logic           err_d, busy_d, fault_d, sel_d, start_d;
  logic [1:0]     gid_d;
  logic [63:0]    f1_d, f2_d;

  logic [1:0]     win, idx;
  logic           win_vld;
  logic [7:0]     base;

  // Round-robin search starting at ptr; descending loop so the nearest offset wins.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    idx     = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
    base = {win, 6'd0};
  end

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    wdog_d   = wdog;
    ack_d    = '0;
    start_d  = 1'b0;
    result_d = result;
    err_d    = err;
    fault_d  = fault;
    gid_d    = grant_id;
    f1_d     = unit_f1;
    f2_d     = unit_f2;
    sel_d    = unit_sel;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          gid_d   = win;
          ptr_d   = win + 2'd1;
          f1_d    = req_f1[base +: OPW];
          f2_d    = req_f2[base +: OPW];
          sel_d   = req_sel[win];
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done has priority over a watchdog expiring in the same cycle.
        if (unit_done) begin
          result_d = unit_out;
          err_d    = 1'b0;
          ack_d    = 4'b0001 << grant_id;
          state_d  = S_RESP;
        end else if (wdog == WDOG_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          fault_d  = 1'b1;
          ack_d    = 4'b0001 << grant_id;
          state_d  = S_RESP;
        end else begin
          wdog_d = wdog + WDW'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_50M) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      wdog       <= '0;
      ack        <= '0;
      result     <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= '0;
      fault      <= 1'b0;
      unit_f1    <= '0;
      unit_f2    <= '0;
      unit_sel   <= 1'b0;
      unit_start <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      wdog       <= wdog_d;
      ack        <= ack_d;
      result     <= result_d;
      err        <= err_d;
      busy       <= busy_d;
      grant_id   <= gid_d;
      fault      <= fault_d;
      unit_f1    <= f1_d;
      unit_f2    <= f2_d;
      unit_sel   <= sel_d;
      unit_start <= start_d;
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: random requesters and float-unit model, with a
// transaction-timestamp reference model checked every cycle plus directed scenarios.
module tb_fpu_share_arbiter;

  localparam int unsigned TO      = 150;
  localparam int          FLOAT_L = 129;

  logic         clock_50M = 1'b0;
  logic         reset     = 1'b1;
  logic [3:0]   req       = '0;
  logic [255:0] req_f1    = '0;
  logic [255:0] req_f2    = '0;
  logic [3:0]   req_sel   = '0;
  logic [3:0]   ack;
  logic [127:0] result;
  logic         err, busy, fault, unit_sel, unit_start;
  logic [1:0]   grant_id;
  logic [63:0]  unit_f1, unit_f2;
  logic         unit_done = 1'b0;
  logic [127:0] unit_out  = '0;

  fpu_share_arbiter #(.TIMEOUT(TO)) dut (
    .clock_50M(clock_50M), .reset(reset), .req(req), .req_f1(req_f1), .req_f2(req_f2),
    .req_sel(req_sel), .ack(ack), .result(result), .err(err), .busy(busy),
    .grant_id(grant_id), .fault(fault), .unit_f1(unit_f1), .unit_f2(unit_f2),
    .unit_sel(unit_sel), .unit_start(unit_start), .unit_done(unit_done), .unit_out(unit_out)
  );

  always #10 clock_50M = ~clock_50M;

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit chk_en = 1'b0, spur_en = 1'b0, drop_en = 1'b0;
  int lat_mode = 0;
  logic [3:0] gen_mask = '0, keep_mask = '0;

  // Reference model state: transaction timestamps and expected outputs.
  bit           m_active = 1'b0, m_acked = 1'b0;
  int           m_t0 = 0, m_ptr = 0;
  logic [3:0]   e_ack = '0;
  logic [127:0] e_result = '0;
  logic         e_err = 1'b0, e_busy = 1'b0, e_fault = 1'b0, e_sel = 1'b0, e_start = 1'b0;
  logic [1:0]   e_gid = '0;
  logic [63:0]  e_f1 = '0, e_f2 = '0;
  int           u_due = -1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  initial begin : model_p
    int k, w;
    forever begin
      @(posedge clock_50M);
      cyc     = cyc + 1;
      e_start = 1'b0;
      if (reset) begin
        m_active = 1'b0; m_acked = 1'b0; m_ptr = 0;
        e_ack = '0; e_result = '0; e_err = 1'b0; e_busy = 1'b0; e_gid = '0;
        e_fault = 1'b0; e_f1 = '0; e_f2 = '0; e_sel = 1'b0;
      end else if (m_acked) begin
        m_acked = 1'b0; m_active = 1'b0; e_ack = '0; e_busy = 1'b0;
      end else if (m_active) begin
        k = cyc - m_t0;
        if (k >= 2 && unit_done === 1'b1) begin
          e_result = {e_f2, e_f1}; e_err = 1'b0; e_ack = 4'b0001 << e_gid; m_acked = 1'b1;
        end else if (k == int'(TO) + 1) begin
          e_result = '0; e_err = 1'b1; e_fault = 1'b1; e_ack = 4'b0001 << e_gid; m_acked = 1'b1;
        end
      end else if (req != 4'b0) begin
        w = -1;
        for (int j = 0; j < 4; j++)
          if (w < 0 && req[(m_ptr + j) % 4]) w = (m_ptr + j) % 4;
        m_active = 1'b1; m_t0 = cyc; m_ptr = (w + 1) % 4;
        e_gid = 2'(w); e_f1 = req_f1[64*w +: 64]; e_f2 = req_f2[64*w +: 64];
        e_sel = req_sel[w]; e_start = 1'b1; e_busy = 1'b1;
      end
    end
  end

  initial begin : compare_p
    forever begin
      @(negedge clock_50M);
      if (chk_en) begin
        chk("ack", 128'(ack), 128'(e_ack));
        chk("result", result, e_result);
        chk("err", 128'(err), 128'(e_err));
        chk("busy", 128'(busy), 128'(e_busy));
        chk("grant_id", 128'(grant_id), 128'(e_gid));
        chk("fault", 128'(fault), 128'(e_fault));
        chk("unit_f1", 128'(unit_f1), 128'(e_f1));
        chk("unit_f2", 128'(unit_f2), 128'(e_f2));
        chk("unit_sel", 128'(unit_sel), 128'(e_sel));
        chk("unit_start", 128'(unit_start), 128'(e_start));
      end
    end
  end

  function automatic int pick_lat();
    int r;
    case (lat_mode)
      0: return FLOAT_L;
      1: begin
        r = int'($urandom_range(0, 9));
        if (r < 5) return int'($urandom_range(1, 8));
        if (r < 9) return int'($urandom_range(9, TO));
        return -1;
      end
      2: return -1;
      3: return int'(TO);
      default: return int'($urandom_range(1, 8));
    endcase
  endfunction

  // Float unit: samples operands at completion, result is {f2, f1}.
  initial begin : unit_p
    int l;
    forever begin
      @(negedge clock_50M);
      unit_done = 1'b0;
      unit_out  = {$urandom, $urandom, $urandom, $urandom};
      if (unit_start === 1'b1) begin
        l = pick_lat();
        u_due = (l < 0) ? -1 : cyc + l;
      end else if (u_due == cyc) begin
        unit_done = 1'b1; unit_out = {unit_f2, unit_f1}; u_due = -1;
      end else if (spur_en && !m_active && $urandom_range(0, 7) == 0) begin
        unit_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clock_50M);
    for (int i = 0; i < 4; i++) begin
      if (ack[i] && !keep_mask[i]) req[i] = 1'b0;
      else if (!req[i] && gen_mask[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      else if (req[i] && drop_en && $urandom_range(0, 199) == 0) req[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      req_f1[32*i +: 32] = $urandom;
      req_f2[32*i +: 32] = $urandom;
    end
    req_sel = 4'($urandom);
  endtask

  task automatic wait_ack(output int id, output int at, input int max);
    id = -1; at = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (ack != 4'b0) begin
        for (int j = 0; j < 4; j++) if (ack[j]) id = j;
        at = cyc;
        return;
      end
    end
    n_chk++; n_fail++;
    $display("FAIL wait_ack: no ack within %0d cycles (cycle %0d)", max, cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; keep_mask = '0; gen_mask = '0;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin : main_p
    int id, at, c0, prev;
    step(); chk_en = 1'b1;
    step(); reset = 1'b0;
    chk("reset_outputs", 128'({ack, err, busy, grant_id, fault, unit_sel, unit_start}), 128'(0));

    // Single request with fixed 129-cycle unit.
    lat_mode = 0; step(); c0 = cyc;
    req = 4'b0001; req_sel[0] = 1'b1;
    req_f1[63:0] = 64'h3FF0000000000000; req_f2[63:0] = 64'h4000000000000000;
    step();
    chk("single_start", 128'(unit_start), 128'(1));
    chk("single_sel", 128'(unit_sel), 128'(1));
    chk("single_f1", 128'(unit_f1), 128'(64'h3FF0000000000000));
    wait_ack(id, at, 400);
    chk("single_ack_id", 128'(id), 128'(0));
    chk("single_latency", 128'(at - c0), 128'(131));
    chk("single_result", result, {64'h4000000000000000, 64'h3FF0000000000000});
    chk("single_err", 128'(err), 128'(0));

    // Contention: all four request, each drops after its ack.
    do_reset(); lat_mode = 0; req = 4'b1111; prev = 0;
    for (int n = 0; n < 4; n++) begin
      wait_ack(id, at, 400);
      chk("contention_order", 128'(id), 128'(n));
      if (n > 0) chk("contention_spacing", 128'(at - prev), 128'(132));
      prev = at;
    end

    // Fairness: 0 and 2 re-request continuously.
    do_reset(); lat_mode = 5; keep_mask = 4'b0101; req = 4'b0101;
    for (int n = 0; n < 6; n++) begin
      wait_ack(id, at, 100);
      chk("fairness_order", 128'(id), 128'((n % 2) * 2));
    end

    // Timeout, then fault stays set across a good transaction.
    do_reset(); lat_mode = 2; c0 = cyc; req = 4'b0100;
    wait_ack(id, at, TO + 20);
    chk("timeout_ack_id", 128'(id), 128'(2));
    chk("timeout_latency", 128'(at - c0), 128'(TO + 2));
    chk("timeout_err", 128'(err), 128'(1));
    chk("timeout_result", result, 128'(0));
    chk("timeout_fault", 128'(fault), 128'(1));
    lat_mode = 5; step(); req = 4'b0001;
    wait_ack(id, at, 100);
    chk("after_timeout_err", 128'(err), 128'(0));
    chk("after_timeout_fault", 128'(fault), 128'(1));

    // Done in the same cycle the watchdog expires.
    do_reset(); lat_mode = 3; c0 = cyc; req = 4'b0010;
    wait_ack(id, at, TO + 20);
    chk("tie_latency", 128'(at - c0), 128'(TO + 2));
    chk("tie_err", 128'(err), 128'(0));
    chk("tie_fault", 128'(fault), 128'(0));
    chk("tie_result", result, {e_f2, e_f1});

    // Reset while waiting on the unit; pointer must restart at 0.
    do_reset(); lat_mode = 0; c0 = cyc; req = 4'b0010;
    for (int n = 0; n < 50; n++) step();
    reset = 1'b1;
    step();
    chk("wait_reset_outputs", 128'({ack, err, busy, grant_id, fault, unit_sel, unit_start}), 128'(0));
    chk("wait_reset_f1", 128'(unit_f1), 128'(0));
    reset = 1'b0; req = 4'b1010;
    wait_ack(id, at, 400);
    chk("post_reset_grant", 128'(id), 128'(1));
    wait_ack(id, at, 400);
    chk("post_reset_second", 128'(id), 128'(3));

    // Random traffic with spurious done pulses, drops and one mid-run reset.
    do_reset(); lat_mode = 1; gen_mask = 4'b1111; drop_en = 1'b1; spur_en = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      if (n == 3000) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    gen_mask = '0; drop_en = 1'b0;
    repeat (800) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : guard_p
    #4000000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/fpu_share_arbiter.md
# fpu_share_arbiter

Round-robin arbiter and sequencer that shares one 64-bit two-operand float unit (start/done handshake, 128-bit result) among four requesters. It latches the winning requester's operands and select bit, pulses the unit's start, holds operands stable until done, captures the result and returns it with a one-cycle ack. A watchdog aborts transactions where the unit never signals done. It sits between client FSMs and the float unit.

## Interface
- TIMEOUT, 255: max cycles in WAIT before abort (1..65535, 16-bit counter)
- clock_50M  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  4  per-requester request level, bit i = requester i
- req_f1  in  256  operand 1, requester i at bits [64i+63:64i]
- req_f2  in  256  operand 2, same packing
- req_sel  in  4  per-requester select bit
- ack  out  4  one-hot, one-cycle completion pulse to granted requester
- result  out  128  captured unit result, valid in ack cycle, held until next capture
- err  out  1  high with ack when the transaction timed out
- busy  out  1  high in every state except IDLE
- grant_id  out  2  index of current/last granted requester
- fault  out  1  sticky, set on any timeout, cleared only by reset
- unit_f1  out  64  operand 1 to float unit
- unit_f2  out  64  operand 2 to float unit
- unit_sel  out  1  select to float unit
- unit_start  out  1  one-cycle start pulse
- unit_done  in  1  unit completion pulse
- unit_out  in  128  unit result, valid while unit_done high

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if req != 0 at the edge, pick winner by round-robin from pointer ptr (search ptr, ptr+1, ... mod 4); latch req_f1/req_f2/req_sel slices into unit_f1/unit_f2/unit_sel, grant_id <= winner, ptr <= winner+1 mod 4; -> ISSUE. Else stay.
- ISSUE: unit_start=1 for this cycle only; wdog <= 0; -> WAIT.
- WAIT: unit_f1/unit_f2/unit_sel held constant (unit samples operands at completion, not at start). If unit_done: result <= unit_out, err <= 0; -> RESP. Else if wdog == TIMEOUT-1: result <= 0, err <= 1, fault <= 1; -> RESP. Else wdog++.
- unit_done and timeout in same cycle: done wins, err=0.
- RESP: ack[grant_id]=1 for one cycle; -> IDLE.
- Requesters hold req until ack and must drop it the cycle after ack; a req still high in the following IDLE cycle is a new request.
- req dropped mid-transaction: transaction completes, ack still pulses; no cancel.
- unit_done outside WAIT ignored.
- Operand inputs of non-granted requesters and of the granted one after IDLE are don't-care.
- Reset mid-transaction: immediate return to IDLE, all outputs to reset values, ptr=0; the unit is not told (reset it together).

## Timing
- Reset values: ack=0, result=0, err=0, busy=0, grant_id=0, fault=0, unit_f1=0, unit_f2=0, unit_sel=0, unit_start=0; ptr=0, state IDLE.
- L = cycles from unit_start-high cycle to unit_done-high cycle (129 for the 128-count float unit). req sampled in cycle 0 -> unit_start in cycle 1 -> unit_done in cycle 1+L -> ack in cycle 2+L (131 for the float unit).
- Timeout: ack with err=1 in cycle TIMEOUT+2 after req sampling.
- Back-to-back: next grant sampled in the cycle after ack; pipeline issue rate one transaction per L+3 cycles.
- All outputs registered; no combinational path from req or unit_done to any output.

## Test plan
- Single request: req=0001, f1=0x3FF0000000000000, f2=0x4000000000000000, sel=1 -> unit_start in cycle 1, unit_sel=1, ack=0001 in cycle 131, result={f2,f1}, err=0.
- Contention: req=1111 held, each drops after its ack -> grant order 0,1,2,3; acks spaced 132 cycles; each result matches own operands.
- Fairness: req0 and req2 continuously re-requesting -> grants alternate 0,2,0,2; requesters 1/3 never acked.
- Timeout: TIMEOUT=20, unit_done tied 0, req=0100 -> ack=0100 in cycle 22, err=1, result=0, fault=1 and stays 1 on next good transaction.
- Done/timeout tie: TIMEOUT=20, model asserts unit_done in same cycle watchdog expires -> err=0, result=unit_out, fault=0.
- Reset in WAIT at cycle 50: next cycle busy=0, all outputs 0; new req=1000 after reset granted (ptr=0 search) and completes normally.
